mem_lsu: RTL and testbench
==========================

Name: mem_lsu

Overview:
- Memory-stage load/store unit, directly upstream of the MEM/WB pipeline register.
- Takes the EX/MEM register outputs and runs one data-memory transaction per load/store over a req/ack bus of variable latency.
- Stalls the pipeline until the transaction completes.
- Produces the RegWriteM/RegAddrM/RegDataM triple that MEM/WB captures.
- Performs byte/halfword lane steering, load sign/zero extension, alignment checking and flush handling.

Parameters:
- ADDR_W, 32, data-memory address width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- req  in  1  flush request (same signal that clears MEM/WB)
- instrM  in  32  instruction in MEM stage (pass-through, not decoded here)
- memReadM  in  1  load
- memWriteM  in  1  store
- memSizeM  in  2  access size: 0 byte, 1 half, 2 word (3 treated as word)
- memSignedM  in  1  sign-extend loads
- aluResultM  in  32  effective address / non-memory result
- storeDataM  in  32  rt value for stores
- RegWriteInM  in  1  register write enable from EX/MEM
- RegAddrInM  in  5  destination register from EX/MEM
- dm_req  out  1  bus request
- dm_we  out  1  bus write
- dm_addr  out  ADDR_W  word-aligned bus address ({addr[ADDR_W-1:2],2'b00})
- dm_wdata  out  32  lane-steered store data
- dm_be  out  4  byte enables
- dm_ack  in  1  bus completion (one-cycle pulse)
- dm_rdata  in  32  read data, valid with dm_ack
- stallM  out  1  freeze PC/IF/ID/EX/EXMEM; MEM/WB must not capture
- excAdEL  out  1  misaligned load
- excAdES  out  1  misaligned store
- RegWriteM  out  1  to MEM/WB
- RegAddrM  out  5  to MEM/WB
- RegDataM  out  32  to MEM/WB

Behaviour:
- Reset (asynchronous): state=IDLE; dm_req, dm_we, dm_addr, dm_wdata, dm_be, load buffer all 0.
- Combinational outputs (stallM, exc*, RegWriteM/RegAddrM/RegDataM) follow the reset state:
  - stallM=0.
  - RegWriteM/RegAddrM/RegDataM pass through from inputs; loads have RegWriteM=0 while not in DONE.
- Alignment: half misaligned if addr[0]; word misaligned if addr[1:0]!=0. Byte never misaligned.
- Misaligned access:
  - excAdEL or excAdES asserted combinationally.
  - No bus request, no stall.
  - RegWriteM=0.
- States: IDLE, BUSY, DONE, ABORT.
- IDLE:
  - Aligned load/store with req=0: stallM=1. Next edge: register dm_req=1, dm_we=memWriteM, addr/wdata/be; go BUSY.
  - Non-memory instruction: stallM=0; RegDataM=aluResultM; RegWriteM=RegWriteInM.
  - req=1: no request issued, stay IDLE.
- BUSY:
  - stallM=1.
  - dm_req and all bus outputs held stable until dm_ack.
  - On dm_ack with req=0: latch extended load result into buffer; drop dm_req; go DONE.
  - req=1 before or with ack: go ABORT (or straight to IDLE if ack is the same cycle).
- ABORT:
  - stallM=1; dm_req held until dm_ack.
  - RegWriteM=0.
  - Read data discarded; store still completes (bus cannot cancel).
  - On ack go IDLE.
- DONE:
  - stallM=0 for exactly one cycle.
  - RegDataM = buffered load value; RegWriteM=RegWriteInM (stores pass RegWriteInM, which is 0).
  - Next edge: MEM/WB captures; go IDLE unconditionally.
  - req=1 in DONE: RegWriteM=0, go IDLE.
- Minimum latency: load with same-cycle ack completes in 3 cycles (IDLE→BUSY→DONE).
- Store steering:
  - Byte: be=4'b0001<<addr[1:0]; wdata={4{sd[7:0]}}.
  - Half: be = addr[1] ? 4'b1100 : 4'b0011; wdata={2{sd[15:0]}}.
  - Word: be=4'b1111; wdata=sd.
- Load extraction:
  - Byte: lane addr[1:0]. Half: lane addr[1].
  - Extension is sign or zero per memSignedM; word loads are not extended.
- dm_ack outside BUSY/ABORT is ignored.
- dm_be=0 whenever dm_req=0.
- Reset mid-transaction returns to IDLE immediately; the bus must tolerate dm_req dropping.

Test Plan:
- Reset asserted asynchronously mid-BUSY → dm_req=0, state IDLE, stallM=0 in the same cycle.
- LB, addr=0x1003, memSigned=1, dm_rdata=0x80FF_FFFF, ack 2 cycles after req:
  - stallM high 3 cycles; dm_addr=0x1000.
  - DONE cycle: RegDataM=0xFFFF_FF80, RegWriteM=1.
- SH, addr=0x2002, storeData=0x1234_ABCD → dm_be=4'b1100, dm_wdata=0xABCD_ABCD, dm_we=1, held until ack.
- LW, addr=0x3001 → excAdEL=1, dm_req never asserted, stallM=0, RegWriteM=0.
- LHU, addr=0x4000; req pulsed during BUSY; ack 3 cycles later → dm_req held until ack, RegWriteM=0 throughout, then IDLE.
- ADD (no memory op), aluResult=0x55 → RegDataM=0x55, stallM=0, no bus activity.

Source files
------------

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: runs one req/ack data-memory transaction per
// load/store, stalls the pipeline meanwhile, and forms the MEM/WB write triple.
module mem_lsu #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [31:0]       instrM,
    input  logic              memReadM,
    input  logic              memWriteM,
    input  logic [1:0]        memSizeM,
    input  logic              memSignedM,
    input  logic [31:0]       aluResultM,
    input  logic [31:0]       storeDataM,
    input  logic              RegWriteInM,
    input  logic [4:0]        RegAddrInM,
    output logic              dm_req,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_wdata,
    output logic [3:0]        dm_be,
    input  logic              dm_ack,
    input  logic [31:0]       dm_rdata,
    output logic              stallM,
    output logic              excAdEL,
    output logic              excAdES,
    output logic              RegWriteM,
    output logic [4:0]        RegAddrM,
    output logic [31:0]       RegDataM
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE, ABORT} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] load_buf;
    logic        is_mem;
    logic        misaligned;
    logic        bus_issue;
    logic        bus_drop;
    logic        buf_load;
    logic [3:0]  be_nxt;
    logic [31:0] wdata_nxt;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_ext;
    logic        unused_inputs;

    // The instruction word travels alongside but is not decoded here.
    assign unused_inputs = ^instrM;

    assign is_mem = memReadM | memWriteM;

    always_comb begin
        misaligned = 1'b0;
        if (is_mem) begin
            case (memSizeM)
                2'd0:    misaligned = 1'b0;
                2'd1:    misaligned = aluResultM[0];
                default: misaligned = |aluResultM[1:0];
            endcase
        end
    end

    assign excAdEL = memReadM & misaligned;
    assign excAdES = memWriteM & misaligned;

    always_comb begin
        be_nxt    = 4'b1111;
        wdata_nxt = storeDataM;
        case (memSizeM)
            2'd0: begin
                be_nxt    = 4'b0001 << aluResultM[1:0];
                wdata_nxt = {4{storeDataM[7:0]}};
            end
            2'd1: begin
                be_nxt    = aluResultM[1] ? 4'b1100 : 4'b0011;
                wdata_nxt = {2{storeDataM[15:0]}};
            end
            default: begin
                be_nxt    = 4'b1111;
                wdata_nxt = storeDataM;
            end
        endcase
    end

    always_comb begin
        byte_v   = dm_rdata[{aluResultM[1:0], 3'b000} +: 8];
        half_v   = aluResultM[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        load_ext = dm_rdata;
        case (memSizeM)
            2'd0:    load_ext = {{24{memSignedM & byte_v[7]}}, byte_v};
            2'd1:    load_ext = {{16{memSignedM & half_v[15]}}, half_v};
            default: load_ext = dm_rdata;
        endcase
    end

    // Bus handshake: dm_req rises together with we/addr/wdata/be and all of
    // them hold unchanged until the one-cycle dm_ack; the edge that samples
    // dm_ack drops the request. dm_ack with no request outstanding is ignored.
    always_comb begin
        state_nxt = state;
        stallM    = 1'b0;
        RegWriteM = RegWriteInM;
        RegAddrM  = RegAddrInM;
        RegDataM  = aluResultM;
        bus_issue = 1'b0;
        bus_drop  = 1'b0;
        buf_load  = 1'b0;
        case (state)
            IDLE: begin
                if (misaligned) begin
                    RegWriteM = 1'b0;
                end else if (is_mem) begin
                    if (memReadM) RegWriteM = 1'b0;
                    if (!req) begin
                        stallM    = 1'b1;
                        bus_issue = 1'b1;
                        state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                stallM    = 1'b1;
                RegWriteM = 1'b0;
                if (dm_ack) begin
                    bus_drop = 1'b1;
                    if (req) begin
                        state_nxt = IDLE;
                    end else begin
                        buf_load  = 1'b1;
                        state_nxt = DONE;
                    end
                end else if (req) begin
                    state_nxt = ABORT;
                end
            end
            ABORT: begin
                stallM    = 1'b1;
                RegWriteM = 1'b0;
                if (dm_ack) begin
                    bus_drop  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                if (memReadM) RegDataM = load_buf;
                if (req) RegWriteM = 1'b0;
            end
            default: state_nxt = IDLE;
        endcase
        // Reset clears the FSM at once, so the pipeline must not see a stall.
        if (reset) stallM = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            dm_req   <= 1'b0;
            dm_we    <= 1'b0;
            dm_addr  <= '0;
            dm_wdata <= '0;
            dm_be    <= '0;
            load_buf <= '0;
        end else begin
            state <= state_nxt;
            if (bus_issue) begin
                dm_req   <= 1'b1;
                dm_we    <= memWriteM;
                dm_addr  <= {aluResultM[ADDR_W-1:2], 2'b00};
                dm_wdata <= wdata_nxt;
                dm_be    <= be_nxt;
            end else if (bus_drop) begin
                dm_req   <= 1'b0;
                dm_we    <= 1'b0;
                dm_addr  <= '0;
                dm_wdata <= '0;
                dm_be    <= '0;
            end
            if (buf_load) load_buf <= load_ext;
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: hand-derived vector table, randomized ops against an
// arithmetic reference model, and an asynchronous reset in mid-transaction.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic [31:0] instrM;
    logic        memReadM;
    logic        memWriteM;
    logic [1:0]  memSizeM;
    logic        memSignedM;
    logic [31:0] aluResultM;
    logic [31:0] storeDataM;
    logic        RegWriteInM;
    logic [4:0]  RegAddrInM;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        stallM;
    logic        excAdEL;
    logic        excAdES;
    logic        RegWriteM;
    logic [4:0]  RegAddrM;
    logic [31:0] RegDataM;

    always #5 clk = ~clk;

    mem_lsu #(.ADDR_W(32)) dut (
        .clk(clk), .reset(reset), .req(req), .instrM(instrM),
        .memReadM(memReadM), .memWriteM(memWriteM), .memSizeM(memSizeM),
        .memSignedM(memSignedM), .aluResultM(aluResultM), .storeDataM(storeDataM),
        .RegWriteInM(RegWriteInM), .RegAddrInM(RegAddrInM),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_be(dm_be), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .stallM(stallM), .excAdEL(excAdEL), .excAdES(excAdES),
        .RegWriteM(RegWriteM), .RegAddrM(RegAddrM), .RegDataM(RegDataM)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] sd;
        logic        rwin;
        logic [4:0]  raddr;
        logic [31:0] rdata;
        int          ack_d;     // BUSY cycles without ack before the ack cycle
        int          flush_at;  // BUSY-relative cycle carrying req, -1 for none
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] res;
        logic        el;
        logic        es;
    } vec_t;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    vec_t        tbl[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: byte counts and shifts straight from the lane rules.
    function automatic void model(input logic [1:0] size, input logic sgn,
                                  input logic [31:0] addr, input logic [31:0] sd,
                                  input logic [31:0] rdata, output logic mis,
                                  output logic [3:0] be, output logic [31:0] wdata,
                                  output logic [31:0] res);
        int nb;
        int off;
        logic [31:0] mask;
        nb   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        off  = int'(addr % 4);
        mis  = (addr % nb) != 0;
        be   = 4'((((1 << nb) - 1) << off) & 15);
        for (int i = 0; i < 4; i++) wdata[8*i +: 8] = sd[8*(i % nb) +: 8];
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 1);
        res  = (rdata >> (8 * off)) & mask;
        if (sgn && nb < 4 && res[8*nb-1]) res = res | ~mask;
    endfunction

    task automatic drive_nop();
        memReadM    = 1'b0;
        memWriteM   = 1'b0;
        memSizeM    = 2'($urandom_range(0, 3));
        memSignedM  = 1'($urandom_range(0, 1));
        aluResultM  = $urandom;
        storeDataM  = $urandom;
        RegWriteInM = 1'($urandom_range(0, 1));
        RegAddrInM  = 5'($urandom_range(0, 31));
        instrM      = $urandom;
        req         = 1'b0;
    endtask

    // One non-memory cycle in IDLE, with a stray dm_ack that must be ignored.
    task automatic nop_cycle(input string tag);
        @(posedge clk); #1;
        drive_nop();
        dm_ack   = 1'($urandom_range(0, 1));
        dm_rdata = $urandom;
        @(negedge clk);
        check({tag, ".nop.stall"}, stallM, 0);
        check({tag, ".nop.dm_req"}, dm_req, 0);
        check({tag, ".nop.dm_be"}, dm_be, 0);
        check({tag, ".nop.exc"}, {excAdEL, excAdES}, 0);
        check({tag, ".nop.wr"}, RegWriteM, RegWriteInM);
        check({tag, ".nop.data"}, RegDataM, aluResultM);
    endtask

    task automatic run_op(input vec_t v, input string tag);
        logic mem;
        logic mis;
        logic flush_done;
        bit   aborted;
        int   stalls;
        logic [31:0] exp_v;
        mem     = v.rd | v.wr;
        mis     = v.el | v.es;
        aborted = 0;
        stalls  = 0;
        @(posedge clk); #1;
        memReadM    = v.rd;
        memWriteM   = v.wr;
        memSizeM    = v.size;
        memSignedM  = v.sgn;
        aluResultM  = v.addr;
        storeDataM  = v.sd;
        RegWriteInM = v.rwin;
        RegAddrInM  = v.raddr;
        instrM      = $urandom;
        req         = 1'b0;
        dm_ack      = 1'b0;
        @(negedge clk);
        check({tag, ".excAdEL"}, excAdEL, v.el);
        check({tag, ".excAdES"}, excAdES, v.es);
        check({tag, ".idle.dm_req"}, dm_req, 0);
        check({tag, ".idle.addr"}, RegAddrM, v.raddr);
        if (!mem || mis) begin
            check({tag, ".idle.stall"}, stallM, 0);
            check({tag, ".idle.wr"}, RegWriteM, mis ? 1'b0 : v.rwin);
            if (!mem) check({tag, ".idle.data"}, RegDataM, v.addr);
            return;
        end
        check({tag, ".idle.stall"}, stallM, 1);
        check({tag, ".idle.wr"}, RegWriteM, v.rd ? 1'b0 : v.rwin);
        stalls += int'(stallM);
        if (v.rd) exp_q.push_back(v.res);
        for (int k = 0; k <= v.ack_d; k++) begin
            @(posedge clk); #1;
            req      = (k == v.flush_at);
            dm_ack   = (k == v.ack_d);
            dm_rdata = (k == v.ack_d) ? v.rdata : $urandom;
            @(negedge clk);
            check({tag, ".busy.stall"}, stallM, 1);
            check({tag, ".busy.dm_req"}, dm_req, 1);
            check({tag, ".busy.dm_we"}, dm_we, v.wr);
            check({tag, ".busy.dm_addr"}, dm_addr, {v.addr[31:2], 2'b00});
            if (v.wr) begin
                check({tag, ".busy.dm_be"}, dm_be, v.be);
                check({tag, ".busy.dm_wdata"}, dm_wdata, v.wdata);
            end
            check({tag, ".busy.wr"}, RegWriteM, 0);
            stalls += int'(stallM);
            if (req) aborted = 1;
        end
        @(posedge clk); #1;
        dm_ack     = 1'b0;
        dm_rdata   = $urandom;
        flush_done = (v.flush_at == v.ack_d + 1);
        req        = flush_done;
        if (aborted) begin
            drive_nop();
            RegWriteInM = 1'b0;
            @(negedge clk);
            check({tag, ".abort.stall"}, stallM, 0);
            check({tag, ".abort.dm_req"}, dm_req, 0);
            check({tag, ".abort.dm_be"}, dm_be, 0);
            check({tag, ".abort.wr"}, RegWriteM, 0);
            if (v.rd) exp_v = exp_q.pop_front();
        end else begin
            @(negedge clk);
            check({tag, ".done.stall"}, stallM, 0);
            check({tag, ".done.dm_req"}, dm_req, 0);
            check({tag, ".done.dm_be"}, dm_be, 0);
            check({tag, ".done.wr"}, RegWriteM, flush_done ? 1'b0 : v.rwin);
            check({tag, ".done.addr"}, RegAddrM, v.raddr);
            if (v.rd) begin
                exp_v = exp_q.pop_front();
                check({tag, ".done.data"}, RegDataM, exp_v);
            end
            check({tag, ".stall_cycles"}, stalls, 2 + v.ack_d);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired, n_checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        logic m;

        // rd wr size sgn addr sd rwin raddr rdata ack_d flush_at be wdata res el es
        tbl[0]  = '{1, 0, 2'd0, 1, 32'h0000_1003, 32'h0, 1, 5'd3, 32'h80FF_FFFF, 1, -1, 4'b1000, 32'h0, 32'hFFFF_FF80, 0, 0};
        tbl[1]  = '{0, 1, 2'd1, 0, 32'h0000_2002, 32'h1234_ABCD, 0, 5'd0, 32'h0, 2, -1, 4'b1100, 32'hABCD_ABCD, 32'h0, 0, 0};
        tbl[2]  = '{1, 0, 2'd2, 0, 32'h0000_3001, 32'h0, 1, 5'd4, 32'h0, 0, -1, 4'b0000, 32'h0, 32'h0, 1, 0};
        tbl[3]  = '{1, 0, 2'd1, 0, 32'h0000_4000, 32'h0, 1, 5'd5, 32'h1111_2222, 3, 0, 4'b0011, 32'h0, 32'h2222, 0, 0};
        tbl[4]  = '{0, 0, 2'd0, 0, 32'h0000_0055, 32'h0, 1, 5'd9, 32'h0, 0, -1, 4'b0000, 32'h0, 32'h0, 0, 0};
        tbl[5]  = '{0, 1, 2'd0, 0, 32'h0000_5001, 32'h0000_00A7, 0, 5'd0, 32'h0, 0, -1, 4'b0010, 32'hA7A7_A7A7, 32'h0, 0, 0};
        tbl[6]  = '{1, 0, 2'd1, 1, 32'h0000_6002, 32'h0, 1, 5'd6, 32'h8001_1234, 0, -1, 4'b1100, 32'h0, 32'hFFFF_8001, 0, 0};
        tbl[7]  = '{1, 0, 2'd0, 0, 32'h0000_7001, 32'h0, 1, 5'd7, 32'h0000_9A00, 1, -1, 4'b0010, 32'h0, 32'h0000_009A, 0, 0};
        tbl[8]  = '{1, 0, 2'd2, 0, 32'h0000_8000, 32'h0, 1, 5'd8, 32'hDEAD_BEEF, 2, -1, 4'b1111, 32'h0, 32'hDEAD_BEEF, 0, 0};
        tbl[9]  = '{0, 1, 2'd2, 0, 32'h0000_9002, 32'h0, 0, 5'd0, 32'h0, 0, -1, 4'b0000, 32'h0, 32'h0, 0, 1};
        tbl[10] = '{0, 1, 2'd1, 0, 32'h0000_A001, 32'h0, 0, 5'd0, 32'h0, 0, -1, 4'b0000, 32'h0, 32'h0, 0, 1};
        tbl[11] = '{1, 0, 2'd1, 1, 32'h0000_B003, 32'h0, 1, 5'd11, 32'h0, 0, -1, 4'b0000, 32'h0, 32'h0, 1, 0};
        tbl[12] = '{1, 0, 2'd3, 1, 32'h0000_C000, 32'h0, 1, 5'd12, 32'h8234_5678, 0, -1, 4'b1111, 32'h0, 32'h8234_5678, 0, 0};
        tbl[13] = '{1, 0, 2'd2, 0, 32'h0000_D000, 32'h0, 1, 5'd13, 32'h0000_0001, 1, 2, 4'b1111, 32'h0, 32'h0000_0001, 0, 0};
        tbl[14] = '{1, 0, 2'd0, 0, 32'h0000_E000, 32'h0, 1, 5'd14, 32'h0000_00FF, 1, 1, 4'b0001, 32'h0, 32'h0000_00FF, 0, 0};
        tbl[15] = '{0, 1, 2'd0, 0, 32'h0000_F003, 32'h0000_0055, 0, 5'd0, 32'h0, 0, -1, 4'b1000, 32'h5555_5555, 32'h0, 0, 0};
        tbl[16] = '{0, 1, 2'd2, 0, 32'h0001_0000, 32'hCAFE_F00D, 0, 5'd0, 32'h0, 2, 0, 4'b1111, 32'hCAFE_F00D, 32'h0, 0, 0};

        // Clock/reset block
        reset  = 1'b1;
        dm_ack = 1'b0;
        dm_rdata = 32'h0;
        drive_nop();
        repeat (2) @(negedge clk);
        check("rst.dm_req", dm_req, 0);
        check("rst.dm_we", dm_we, 0);
        check("rst.dm_addr", dm_addr, 0);
        check("rst.dm_wdata", dm_wdata, 0);
        check("rst.dm_be", dm_be, 0);
        check("rst.stall", stallM, 0);
        check("rst.data", RegDataM, aluResultM);
        reset = 1'b0;
        nop_cycle("rst");

        for (int i = 0; i < 17; i++) begin
            run_op(tbl[i], $sformatf("vec%0d", i));
            nop_cycle($sformatf("vec%0d", i));
        end

        // Asynchronous reset arriving between edges while a load is in BUSY.
        v = '{1, 0, 2'd2, 0, 32'h0000_0100, 32'h0, 1, 5'd1, 32'h0, 0, -1, 4'b1111, 32'h0, 32'h0, 0, 0};
        @(posedge clk); #1;
        memReadM = 1'b1; memWriteM = 1'b0; memSizeM = 2'd2; aluResultM = v.addr;
        RegWriteInM = 1'b1; RegAddrInM = 5'd1; req = 1'b0; dm_ack = 1'b0;
        @(posedge clk); #2;
        check("arst.busy.dm_req", dm_req, 1);
        check("arst.busy.stall", stallM, 1);
        reset = 1'b1;
        #1;
        check("arst.dm_req", dm_req, 0);
        check("arst.dm_be", dm_be, 0);
        check("arst.stall", stallM, 0);
        drive_nop();
        @(negedge clk);
        reset = 1'b0;
        nop_cycle("arst");
        run_op(tbl[0], "arst.after");
        nop_cycle("arst.after");

        for (int i = 0; i < 200; i++) begin
            int kind;
            kind       = $urandom_range(0, 2);
            v.rd       = (kind == 1);
            v.wr       = (kind == 2);
            v.size     = 2'($urandom_range(0, 3));
            v.sgn      = 1'($urandom_range(0, 1));
            v.addr     = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (v.size == 2'd1) v.addr[0] = 1'b0;
                else if (v.size != 2'd0) v.addr[1:0] = 2'b00;
            end
            v.sd       = $urandom;
            v.rdata    = $urandom;
            v.rwin     = v.wr ? 1'b0 : 1'($urandom_range(0, 1));
            v.raddr    = 5'($urandom_range(0, 31));
            v.ack_d    = $urandom_range(0, 4);
            v.flush_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, v.ack_d + 1)) : -1;
            model(v.size, v.sgn, v.addr, v.sd, v.rdata, m, v.be, v.wdata, v.res);
            v.el = v.rd & m;
            v.es = v.wr & m;
            run_op(v, $sformatf("rnd%0d", i));
            nop_cycle($sformatf("rnd%0d", i));
        end

        check("exp_q.empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
